// File: rtl/risc_pkg.sv
// Constants shared by the KGP-RISC CPU top, instruction memory and data memory.
// Keeping them here stops the memories and the datapath drifting apart in width or size.
package risc_pkg;

    localparam int XLEN         = 32;
    localparam int ADDR_BITS    = 32;
    localparam int DMEM_DEPTH   = 1024;
    localparam int DMEM_IDX_W   = $clog2(DMEM_DEPTH);

endpackage

// File: rtl/data_memory.sv
// Word-addressed data memory on the load/store path: synchronous reset-clear and write,
// combinational read that is forced to zero whenever memread is low.
module data_memory
    import risc_pkg::*;
#(
    parameter int DATA_W = XLEN,
    parameter int ADDR_W = ADDR_BITS,
    parameter int DEPTH  = DMEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memread,
    input  logic              memwrite,
    input  logic [DATA_W-1:0] writedata,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] readdata
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [IDX_W-1:0]  idx;

    // Upper address bits are dropped on purpose, so addresses wrap modulo DEPTH.
    assign idx = address[IDX_W-1:0];

    logic unused_addr_hi;
    assign unused_addr_hi = ^address[ADDR_W-1:IDX_W];

    // Reset clears every word and takes priority over a write in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (memwrite) begin
            mem[idx] <= writedata;
        end
    end

    // No forwarding: a simultaneous read sees the old word until the edge.
    assign readdata = memread ? mem[idx] : '0;

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: reset, write/read, gating, same-address read/write, wrap.
module tb_data_memory;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int DEPTH  = 1024;

    logic              clk;
    logic              rst;
    logic              memread;
    logic              memwrite;
    logic [DATA_W-1:0] writedata;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] readdata;

    int n_cmp = 0;
    int n_err = 0;

    data_memory #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .memread  (memread),
        .memwrite (memwrite),
        .writedata(writedata),
        .address  (address),
        .readdata (readdata)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one rising edge, then settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [DATA_W-1:0] exp);
        #1;
        n_cmp++;
        assert (readdata === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, readdata, exp);
        end
    endtask

    task automatic write_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        memwrite  = 1'b1;
        address   = a;
        writedata = d;
        tick();
        memwrite  = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] exp);
        memread = 1'b1;
        address = a;
        check(tag, exp);
    endtask

    initial begin
        rst       = 1'b1;
        memread   = 1'b1;
        memwrite  = 1'b1;
        address   = 32'd5;
        writedata = 32'd77;
        @(negedge clk);

        // reset edge with a competing write
        tick();
        check("reset_readdata", 32'd0);
        rst      = 1'b0;
        memwrite = 1'b0;
        tick();
        read_check("reset_addr5_kept_zero", 32'd5, 32'd0);
        read_check("reset_addr9_zero", 32'd9, 32'd0);

        // basic write then same-cycle read
        memread = 1'b0;
        write_word(32'd0, 32'd123);
        read_check("basic_read0", 32'd0, 32'd123);

        // memwrite low must not store
        memread   = 1'b0;
        address   = 32'd1;
        writedata = 32'd55;
        tick();
        read_check("no_write_when_disabled", 32'd1, 32'd0);

        // sequential fill, overwriting the 123 at word 0
        memread = 1'b0;
        for (int i = 0; i < 10; i++) begin
            write_word(i, i);
        end
        for (int i = 0; i < 10; i++) begin
            read_check($sformatf("fill_read%0d", i), i, i);
        end

        // read gating without a clock edge
        memread = 1'b0;
        address = 32'd3;
        check("gate_low_addr3", 32'd0);
        memread = 1'b1;
        check("gate_high_addr3", 32'd3);

        // simultaneous read and write, no bypass
        memread   = 1'b1;
        memwrite  = 1'b1;
        address   = 32'd4;
        writedata = 32'hDEADBEEF;
        check("rw_before_edge", 32'd4);
        tick();
        memwrite = 1'b0;
        check("rw_after_edge", 32'hDEADBEEF);

        // address wrap
        memread = 1'b0;
        write_word(DEPTH + 2, 32'hA5);
        read_check("wrap_read2", 32'd2, 32'hA5);
        read_check("wrap_read_alias", DEPTH + 2, 32'hA5);
        read_check("wrap_alias_depth_is_0", DEPTH, 32'd0);
        memread = 1'b0;
        address = 32'd2;
        check("gate_low_nonzero_word", 32'd0);

        // mid-operation reset wipes everything
        rst = 1'b1;
        tick();
        rst = 1'b0;
        read_check("clear_read2", 32'd2, 32'd0);
        read_check("clear_read4", 32'd4, 32'd0);
        for (int i = 0; i < 10; i++) begin
            read_check($sformatf("clear_read%0d", i), i, 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // watchdog so the run always ends
    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Word-addressed 32-bit data memory for the KGP-RISC datapath, on the load/store path after the ALU.
- Synchronous writes on the rising clock edge.
- Combinational reads, gated by memread.
- Synchronous reset clears the entire array, giving simulation and hardware a known initial state.

Parameters:
- DATA_W, 32, word width in bits.
- ADDR_W, 32, width of the address port.
- DEPTH, 1024, number of words; must be a power of two.
- IDX_W, $clog2(DEPTH), derived local parameter: index bits taken from address.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- memread  input  1  read enable; when 1, readdata shows the addressed word.
- memwrite  input  1  write enable; when 1 at a rising edge, writedata is stored.
- writedata  input  DATA_W  data to store.
- address  input  ADDR_W  word address; one increment selects the next 32-bit word.
- readdata  output  DATA_W  read data.

Behaviour:
- Storage is an array mem[0..DEPTH-1] of DATA_W bits.
- Index = address[IDX_W-1:0]. Upper address bits are ignored, so addresses wrap modulo DEPTH. Address DEPTH aliases word 0.
- Reset:
  - On a rising edge with rst=1, every word is cleared to 0.
  - memwrite is ignored in that cycle; reset has priority over write.
  - Reset mid-operation discards all stored contents.
- Write:
  - On a rising edge with rst=0 and memwrite=1, mem[index] <= writedata.
  - Write latency is one edge.
  - No byte enables; full-word writes only.
- Read:
  - Combinational: readdata = mem[index] when memread=1, else 0.
  - readdata follows address and memread changes within the same cycle, with no clock needed.
- readdata value by condition:
  - During reset, and after reset with memread=1, readdata = 0.
  - With memread=0, readdata = 0 regardless of array contents.
- memread=1 and memwrite=1 together, same address:
  - Before the edge, readdata shows the old word.
  - After the edge, it shows writedata.
  - No bypass or forwarding.
- memwrite=0 and memread=0: array unchanged, readdata = 0.
- X/undefined enables are not supported. Inputs are held stable around the rising edge.

Decomposition:
- Shared package (risc_pkg): DATA_W=32 and the default data-memory DEPTH, so the CPU top and the instruction memory use the same constants.
- No sub-module. The block is a single module holding:
  - the array,
  - the synchronous reset/write process,
  - the combinational read mux.

Test Plan:
- Reset: assert rst for one edge with memwrite=1, address=5, writedata=77, memread=1 -> readdata=0; mem[5] stays 0 after rst deasserts.
- Basic write/read: rst=0; address=0, writedata=123, memwrite=1 for one edge; then memwrite=0, memread=1, address=0 -> readdata=123 in the same cycle.
- Sequential fill: for i=0..9 write writedata=i at address=i, one edge each; then read addresses 0..9 -> readdata=i each. Address 0 now holds 0, overwriting the earlier 123.
- Read gating: with mem[3]=3, memread=0, address=3 -> readdata=0; raise memread -> readdata=3 without a clock edge.
- Simultaneous read/write: mem[4]=4; memread=1, memwrite=1, address=4, writedata=0xDEADBEEF -> readdata=4 before the edge, 0xDEADBEEF after it.
- Wrap and reset-clear: write 0xA5 at address=DEPTH+2 -> reading address 2 returns 0xA5. Then one rst edge -> reads of addresses 2 and 0..9 all return 0.
